// File: rtl/mul_4x1_pkg.sv
// Shared select encodings for the 4:1 multiplexer slice.
package mul_4x1_pkg;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;
  localparam logic [1:0] SEL_D3 = 2'b11;

endpackage

// File: rtl/mul_4x1_mux4_comb.sv
// Purely combinational 4:1 selector; an unknown select drives all-X.
module mux4_comb
  import mul_4x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] F
);

  always_comb begin
    F = 'x;
    case (addr)
      SEL_D0:  F = D0;
      SEL_D1:  F = D1;
      SEL_D2:  F = D2;
      SEL_D3:  F = D3;
      default: F = 'x;
    endcase
  end

endmodule

// File: rtl/mul_4x1.sv
// 4:1 mux with a registered output copy and a one-cycle select-change pulse.
module mul_4x1
  import mul_4x1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       addr,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] F_q,
  output logic             sel_chg
);

  logic [1:0] addr_q;

  mux4_comb #(.WIDTH(WIDTH)) u_mux (
    .addr (addr),
    .D0   (D0),
    .D1   (D1),
    .D2   (D2),
    .D3   (D3),
    .F    (F)
  );

  // addr_q resets to SEL_D0, so the first edge after release compares against 00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      F_q     <= '0;
      addr_q  <= SEL_D0;
      sel_chg <= 1'b0;
    end else begin
      F_q     <= F;
      addr_q  <= addr;
      sel_chg <= (addr != addr_q);
    end
  end

endmodule

// File: tb/tb_mul_4x1.sv
// Self-checking bench for mul_4x1 with WIDTH=4 and a behavioural reference model.
module tb_mul_4x1;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [1:0]   addr;
  logic [W-1:0] D0, D1, D2, D3;
  logic [W-1:0] F, F_q;
  logic         sel_chg;

  int checks = 0;
  int errors = 0;

  mul_4x1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .addr    (addr),
    .D0      (D0),
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .F       (F),
    .F_q     (F_q),
    .sel_chg (sel_chg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // reference: selected value straight from the data inputs by index
  function automatic logic [W-1:0] ref_sel(input logic [1:0] a, input logic [W-1:0] d0,
                                           input logic [W-1:0] d1, input logic [W-1:0] d2,
                                           input logic [W-1:0] d3);
    logic [W-1:0] d [4];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    return d[a];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; addr = 2'b00; D0 = '0; D1 = '0; D2 = '0; D3 = '0;
    #1;
    checks++; if (F_q !== '0) begin errors++; $display("FAIL reset_fq: got %h want 0", F_q); end
    checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL reset_selchg: got %b want 0", sel_chg); end
    @(posedge clk); #1;
    checks++; if (F_q !== '0) begin errors++; $display("FAIL reset_hold_fq: got %h want 0", F_q); end
    D0 = 4'h9; addr = 2'b00; #1;
    checks++; if (F !== 4'h9) begin errors++; $display("FAIL reset_f_tracks: got %h want 9", F); end
    D0 = '0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL release_selchg_00: got %b want 0", sel_chg); end
    checks++; if (F_q !== '0) begin errors++; $display("FAIL release_fq: got %h want 0", F_q); end
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    addr = 2'b00; D0 = '0; D1 = '0; D2 = '0; D3 = '0; #1;
    checks++; if (F !== '0) begin errors++; $display("FAIL pass_pre: got %h want 0", F); end
    D0 = 4'h1; #1;
    checks++; if (F !== 4'h1) begin errors++; $display("FAIL pass_high: got %h want 1", F); end
    D0 = 4'h0; #1;
    checks++; if (F !== 4'h0) begin errors++; $display("FAIL pass_low: got %h want 0", F); end
  endtask

  task automatic test_sweep();
    logic [1:0] seq [3];
    seq[0] = 2'b01; seq[1] = 2'b11; seq[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      D0 = '0; D1 = '0; D2 = '0; D3 = '0; addr = seq[i]; #1;
      checks++; if (F !== '0) begin errors++; $display("FAIL sweep_pre a=%b: got %h want 0", seq[i], F); end
      case (seq[i])
        2'b01:   D1 = 4'h1;
        2'b10:   D2 = 4'h1;
        default: D3 = 4'h1;
      endcase
      #1;
      checks++; if (F !== 4'h1) begin errors++; $display("FAIL sweep_high a=%b: got %h want 1", seq[i], F); end
      D1 = '0; D2 = '0; D3 = '0; #1;
      checks++; if (F !== '0) begin errors++; $display("FAIL sweep_low a=%b: got %h want 0", seq[i], F); end
    end
  endtask

  task automatic test_isolation();
    @(negedge clk);
    addr = 2'b10; D0 = '0; D1 = '0; D2 = '0; D3 = '0; #1;
    D0 = 4'h1; #1;
    checks++; if (F !== '0) begin errors++; $display("FAIL iso_d0: got %h want 0", F); end
    D1 = 4'h1; #1;
    checks++; if (F !== '0) begin errors++; $display("FAIL iso_d1: got %h want 0", F); end
    D3 = 4'h1; #1;
    checks++; if (F !== '0) begin errors++; $display("FAIL iso_d3: got %h want 0", F); end
    D0 = '0; D1 = '0; D3 = '0;
  endtask

  task automatic test_registered();
    @(negedge clk);
    addr = 2'b11; D0 = 4'h3; D1 = 4'h5; D2 = 4'h6; D3 = 4'h0;
    @(posedge clk); #1;
    checks++; if (F_q !== 4'h0) begin errors++; $display("FAIL reg_base: got %h want 0", F_q); end
    @(negedge clk);
    D3 = 4'hA; #1;
    checks++; if (F !== 4'hA) begin errors++; $display("FAIL reg_f: got %h want a", F); end
    checks++; if (F_q !== 4'h0) begin errors++; $display("FAIL reg_early: got %h want 0", F_q); end
    @(posedge clk); #1;
    checks++; if (F_q !== 4'hA) begin errors++; $display("FAIL reg_late: got %h want a", F_q); end
  endtask

  task automatic test_sel_chg();
    @(negedge clk); addr = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL selchg_idle: got %b want 0", sel_chg); end
    @(negedge clk); addr = 2'b01; #1;
    checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL selchg_early: got %b want 0", sel_chg); end
    @(posedge clk); #1;
    checks++; if (sel_chg !== 1'b1) begin errors++; $display("FAIL selchg_pulse: got %b want 1", sel_chg); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL selchg_hold%0d: got %b want 0", i, sel_chg); end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); addr = 2'b00; D0 = 4'h1; D1 = 4'h2;
    @(posedge clk); #1;
    checks++; if (F_q !== 4'h1) begin errors++; $display("FAIL mid_pre_fq: got %h want 1", F_q); end
    checks++; if (sel_chg !== 1'b1) begin errors++; $display("FAIL mid_pre_selchg: got %b want 1", sel_chg); end
    #2; rst_n = 1'b0; #1;
    checks++; if (F_q !== '0) begin errors++; $display("FAIL mid_fq: got %h want 0", F_q); end
    checks++; if (sel_chg !== 1'b0) begin errors++; $display("FAIL mid_selchg: got %b want 0", sel_chg); end
    checks++; if (F !== 4'h1) begin errors++; $display("FAIL mid_f: got %h want 1", F); end
    addr = 2'b01; #1;
    checks++; if (F !== 4'h2) begin errors++; $display("FAIL mid_f_track: got %h want 2", F); end
    @(negedge clk); addr = 2'b10; D2 = 4'h7; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (sel_chg !== 1'b1) begin errors++; $display("FAIL release_selchg_10: got %b want 1", sel_chg); end
    checks++; if (F_q !== 4'h7) begin errors++; $display("FAIL release_fq_d2: got %h want 7", F_q); end
  endtask

  task automatic test_random();
    logic [1:0]   prev_a;
    logic [W-1:0] exp_f;
    logic         exp_sel;
    @(negedge clk); addr = 2'b00;
    @(posedge clk); @(posedge clk);
    prev_a = 2'b00;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      addr = 2'($urandom_range(0, 3));
      D0 = W'($urandom); D1 = W'($urandom); D2 = W'($urandom); D3 = W'($urandom);
      #1;
      exp_f = ref_sel(addr, D0, D1, D2, D3);
      checks++; if (F !== exp_f) begin errors++; $display("FAIL rand_f n=%0d: got %h want %h", n, F, exp_f); end
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0; #1;
        checks++; if (F_q !== '0 || sel_chg !== 1'b0) begin errors++; $display("FAIL rand_rst n=%0d: got fq=%h sel=%b want 0/0", n, F_q, sel_chg); end
        checks++; if (F !== exp_f) begin errors++; $display("FAIL rand_rst_f n=%0d: got %h want %h", n, F, exp_f); end
        #1; rst_n = 1'b1;
        prev_a = 2'b00;
      end
      exp_sel = (addr != prev_a);
      prev_a  = addr;
      @(posedge clk); #1;
      checks++; if (F_q !== exp_f) begin errors++; $display("FAIL rand_fq n=%0d: got %h want %h", n, F_q, exp_f); end
      checks++; if (sel_chg !== exp_sel) begin errors++; $display("FAIL rand_sel n=%0d: got %b want %b", n, sel_chg, exp_sel); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sweep();
    test_isolation();
    test_registered();
    test_sel_chg();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
